// File: rtl/branch_checkpoint_table_pkg.sv
// Shared sizing and types for the branch checkpoint table and its neighbours.
package branch_checkpoint_table_pkg;

  localparam int BRANCH_NUM             = 4;
  localparam int BRANCH_NUM_INDEX       = $clog2(BRANCH_NUM);
  localparam int REG_NUM                = 32;
  localparam int PHYS_REG_NUM_INDEX     = 6;
  localparam int ACTIVE_LIST_SIZE_INDEX = 5;

  // One physical register tag per architectural register.
  typedef logic [REG_NUM-1:0][PHYS_REG_NUM_INDEX-1:0] rename_map_t;

  typedef logic [BRANCH_NUM-1:0]         branch_mask_t;
  typedef logic [BRANCH_NUM_INDEX-1:0]   branch_idx_t;
  typedef logic [ACTIVE_LIST_SIZE_INDEX-1:0] al_id_t;
  typedef logic [PHYS_REG_NUM_INDEX-1:0] phys_reg_t;

endpackage

// File: rtl/branch_state_ifc.sv
// Checkpoint table state as seen by branch_misprediction. The table drives
// every field through the "out" view; branch_misprediction hands back the
// corrected valid vector and write pointer through the "in" view.
interface branch_state_ifc;
  import branch_checkpoint_table_pkg::*;

  branch_mask_t                   valid;
  al_id_t      [BRANCH_NUM-1:0]   branch_id;
  phys_reg_t   [BRANCH_NUM-1:0]   free_head_pointer;
  rename_map_t [BRANCH_NUM-1:0]   rename_buffer;
  branch_idx_t                    write_pointer;
  branch_mask_t                   ds_valid;

  modport out (
    output valid,
    output branch_id,
    output free_head_pointer,
    output rename_buffer,
    output write_pointer,
    output ds_valid
  );

  modport in (
    input valid,
    input write_pointer
  );

endinterface

// File: rtl/branch_checkpoint_table.sv
// Per-branch checkpoint store: one slot per in-flight branch holding its
// active-list ID, free-list head snapshot and rename-map snapshot.
//
// Handshake: alloc_req is a request, alloc_ready is the grant. A slot is
// written only on a cycle where both are high; a request seen while
// alloc_ready is low is dropped and rename must keep presenting it.
// alloc_ready never depends on alloc_req, so there is no combinational loop.
module branch_checkpoint_table
  import branch_checkpoint_table_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,            // active-high synchronous reset

  input  logic               alloc_req,
  input  al_id_t             alloc_branch_id,
  input  phys_reg_t          alloc_free_head,
  input  rename_map_t        alloc_rename_map,
  output logic               alloc_ready,
  output branch_idx_t        alloc_idx,

  input  logic               ds_mark,
  input  phys_reg_t          ds_free_head,
  input  rename_map_t        ds_rename_map,

  input  logic               resolve_valid,
  input  al_id_t             resolve_branch_id,

  input  logic               recover_valid,
  input  branch_idx_t        recover_idx,
  branch_state_ifc.in        recover_state,

  input  logic               flush,

  branch_state_ifc.out       branch_state
);

  // Registered table state
  branch_mask_t                 valid_q,     valid_d;
  branch_mask_t                 ds_valid_q,  ds_valid_d;
  branch_idx_t                  wp_q,        wp_d;
  al_id_t      [BRANCH_NUM-1:0] id_q,        id_d;
  phys_reg_t   [BRANCH_NUM-1:0] fh_q,        fh_d;
  rename_map_t [BRANCH_NUM-1:0] map_q,       map_d;

  // Derived control
  branch_mask_t resolve_hit;
  branch_mask_t recover_clear;
  branch_idx_t  ds_idx;
  logic         alloc_fire;

  // Grant: target slot free and nothing higher-priority is rewriting the table.
  always_comb begin
    alloc_ready = !valid_q[wp_q] && !recover_valid && !flush && !rst_n;
    alloc_idx   = wp_q;
    alloc_fire  = alloc_req && alloc_ready;
    // The delay slot belongs to the most recently allocated branch.
    ds_idx      = wp_q - 1'b1;
  end

  // Parallel compare of the resolved ID against every slot, plus the
  // one-hot mask of the mispredicted slot.
  always_comb begin
    resolve_hit   = '0;
    recover_clear = '0;
    for (int i = 0; i < BRANCH_NUM; i++) begin
      if (resolve_valid && (id_q[i] == resolve_branch_id)) begin
        resolve_hit[i] = 1'b1;
      end
    end
    recover_clear[recover_idx] = 1'b1;
  end

  // Next-state: flush > recover > merged {resolve, ds_mark, alloc}.
  always_comb begin
    valid_d    = valid_q;
    ds_valid_d = ds_valid_q;
    wp_d       = wp_q;
    id_d       = id_q;
    fh_d       = fh_q;
    map_d      = map_q;

    if (flush) begin
      // Payload is left in place; only the bookkeeping is cleared.
      valid_d    = '0;
      ds_valid_d = '0;
      wp_d       = '0;
    end else if (recover_valid) begin
      // Take the corrected view from branch_misprediction, drop the
      // mispredicted slot itself, and still honour a same-cycle resolve.
      valid_d = recover_state.valid & ~recover_clear & ~resolve_hit;
      wp_d    = recover_state.write_pointer;
    end else begin
      // Resolve only clears bits; a hit on an invalid slot is harmless.
      valid_d = valid_q & ~resolve_hit;

      // Delay slot refreshes the youngest live checkpoint's snapshot.
      if (ds_mark && valid_q[ds_idx]) begin
        ds_valid_d[ds_idx] = 1'b1;
        fh_d[ds_idx]       = ds_free_head;
        map_d[ds_idx]      = ds_rename_map;
      end

      // Alloc is applied last so it wins if it ever targets the same slot
      // as the delay slot (only possible with a single-entry table).
      if (alloc_fire) begin
        valid_d[wp_q]    = 1'b1;
        ds_valid_d[wp_q] = 1'b0;
        id_d[wp_q]       = alloc_branch_id;
        fh_d[wp_q]       = alloc_free_head;
        map_d[wp_q]      = alloc_rename_map;
        wp_d             = wp_q + 1'b1;
      end
    end
  end

  // State register with synchronous active-high reset clearing everything.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      valid_q    <= '0;
      ds_valid_q <= '0;
      wp_q       <= '0;
      id_q       <= '0;
      fh_q       <= '0;
      map_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      ds_valid_q <= ds_valid_d;
      wp_q       <= wp_d;
      id_q       <= id_d;
      fh_q       <= fh_d;
      map_q      <= map_d;
    end
  end

  // Every exported field comes straight from a register.
  assign branch_state.valid             = valid_q;
  assign branch_state.ds_valid          = ds_valid_q;
  assign branch_state.write_pointer     = wp_q;
  assign branch_state.branch_id         = id_q;
  assign branch_state.free_head_pointer = fh_q;
  assign branch_state.rename_buffer     = map_q;

endmodule
